// File: rtl/mips_prog_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_prog_loader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HDR_W  = 16;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_e;

    function automatic int unsigned log2c(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface mips_prog_loader_if
    import mips_prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
);
    logic [7:0]        inData;
    logic              inValid;
    logic              inReady;
    logic              memWrEn;
    logic [ADDR_W-1:0] memWrAddr;
    logic [WORD_W-1:0] memWrData;

    modport master (output inData, inValid,
                    input  inReady, memWrEn, memWrAddr, memWrData);
    modport slave  (input  inData, inValid,
                    output inReady, memWrEn, memWrAddr, memWrData);
endinterface

// File: rtl/mips_prog_loader_packer.sv
// Assembles accepted bytes MSB-first into 32-bit words; pulses word_valid_o
// for one cycle after every fourth byte.
module mips_prog_loader_packer
    import mips_prog_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              last_byte_o,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);
    logic [1:0]        idx_q;
    logic [23:0]       sr_q;
    logic              wvalid_q;
    logic [WORD_W-1:0] word_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q    <= '0;
            sr_q     <= '0;
            wvalid_q <= 1'b0;
            word_q   <= '0;
        end else begin
            wvalid_q <= byte_valid_i && (idx_q == 2'd3);
            if (byte_valid_i) begin
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    word_q <= {sr_q, byte_i};
                end else begin
                    sr_q <= {sr_q[15:0], byte_i};
                end
            end
        end
    end

    assign last_byte_o  = (idx_q == 2'd3);
    assign word_valid_o = wvalid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/mips_prog_loader.sv
// Boot loader: header + big-endian words into instruction memory, core held until done.
// Optional trailer checksum byte enabled by defining MIPS_PROG_LOADER_CHECKSUM_EN.
module mips_prog_loader
    import mips_prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_L = 64,
    parameter int unsigned ADDR_W = log2c(ADDR_L),
    parameter int unsigned CNT_W  = HDR_W
) (
    input  logic              clock,
    input  logic              reset,
    mips_prog_loader_if.slave bus,
    output logic              coreHold,
    output logic              done,
    output logic              error
);
`ifdef MIPS_PROG_LOADER_CHECKSUM_EN
    localparam state_e TAIL_ST = CSUM;
    logic [7:0] csum_q;
`else
    localparam state_e TAIL_ST = DONE;
`endif

    state_e            state_q, state_d;
    logic              rdy_en_q;
    logic [7:0]        nhi_q;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  n_hdr;
    logic [ADDR_W:0]   wcnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;
    logic              hold_q;
    logic              accept;
    logic              last_byte;
    logic              last_word;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign accept    = bus.inValid & bus.inReady;
    assign n_hdr     = CNT_W'({nhi_q, bus.inData});
    assign last_word = (CNT_W'(wcnt_q + 1'b1) == n_q);

    mips_prog_loader_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .byte_valid_i (accept && (state_q == DATA)),
        .byte_i       (bus.inData),
        .last_byte_o  (last_byte),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= HDR_HI;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_HI: if (accept) state_d = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (n_hdr > CNT_W'(ADDR_L)) state_d = ERROR;
                    else if (n_hdr == '0)       state_d = TAIL_ST;
                    else                        state_d = DATA;
                end
            end
            DATA: if (accept && last_byte && last_word) state_d = TAIL_ST;
`ifdef MIPS_PROG_LOADER_CHECKSUM_EN
            CSUM: if (accept) state_d = (bus.inData == csum_q) ? DONE : ERROR;
`endif
            default: state_d = state_q;
        endcase
    end

    // inReady is gated by rdy_en_q so it stays low until the first edge after reset.
    always_comb begin
        bus.inReady = 1'b0;
        case (state_q)
            HDR_HI, HDR_LO, DATA: bus.inReady = rdy_en_q;
`ifdef MIPS_PROG_LOADER_CHECKSUM_EN
            CSUM: bus.inReady = rdy_en_q;
`endif
            default: bus.inReady = 1'b0;
        endcase
        bus.memWrEn   = word_valid;
        bus.memWrAddr = addr_q;
        bus.memWrData = word;
        done          = done_q;
        coreHold      = hold_q;
        error         = (state_q == ERROR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdy_en_q <= 1'b0;
            nhi_q    <= '0;
            n_q      <= '0;
            wcnt_q   <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            hold_q   <= 1'b1;
`ifdef MIPS_PROG_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            rdy_en_q <= 1'b1;
            done_q   <= (state_q == DONE);
            hold_q   <= (state_q != DONE);
            if (accept) begin
                case (state_q)
                    HDR_HI: nhi_q <= bus.inData;
                    HDR_LO: n_q   <= n_hdr;
                    DATA: begin
                        if (last_byte) begin
                            addr_q <= wcnt_q[ADDR_W-1:0];
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
`ifdef MIPS_PROG_LOADER_CHECKSUM_EN
                if (state_q != CSUM) csum_q <= csum_q ^ bus.inData;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: vector table, directed corner cases
// and randomized loads against a byte-stream reference model.
module tb_mips_prog_loader;

    localparam int unsigned ADDR_L = 64;
    localparam int unsigned ADDR_W = 6;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [15:0] n;
        int unsigned max_gap;
        bit          exp_done;
        bit          exp_err;
        int unsigned exp_writes;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic coreHold, done, error;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cyc = -1;
    int hold_cyc = -1;
    wr_t wr_q[$];

    mips_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    mips_prog_loader #(.ADDR_L(ADDR_L)) dut (
        .clock    (clk),
        .reset    (rst_n),
        .bus      (bus),
        .coreHold (coreHold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (rst_n) begin
            if (bus.memWrEn) begin
                w.addr = bus.memWrAddr;
                w.data = bus.memWrData;
                w.cyc  = cyc;
                wr_q.push_back(w);
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (!coreHold && hold_cyc < 0) hold_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the image is the first 4N bytes grouped big-endian, written at 0..N-1,
    // and a header larger than the memory writes nothing.
    function automatic void model(input logic [15:0] n, input logic [7:0] d[$],
                                  output wr_t exp[$], output bit ok);
        wr_t w;
        exp.delete();
        ok = (int'(n) <= int'(ADDR_L));
        if (ok) begin
            for (int i = 0; i < int'(n); i++) begin
                w.addr = i;
                w.data = {d[4*i], d[4*i+1], d[4*i+2], d[4*i+3]};
                w.cyc  = 0;
                exp.push_back(w);
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input int unsigned gap,
                             input int unsigned budget, output bit acc);
        acc = 1'b0;
        if (gap > 0) begin
            bus.inValid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.inData  = b;
        bus.inValid = 1'b1;
        for (int unsigned i = 0; i < budget; i++) begin
            if (bus.inReady) begin
                @(negedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input bit chk);
        bus.inValid = 1'b0;
        rst_n = 1'b0;
        #1;
        if (chk) begin
            check("rst_memWrEn", bus.memWrEn, 0);
            check("rst_memWrAddr", bus.memWrAddr, 0);
            check("rst_memWrData", bus.memWrData, 0);
            check("rst_coreHold", coreHold, 1);
            check("rst_done", done, 0);
            check("rst_error", error, 0);
            check("rst_inReady", bus.inReady, 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if (chk) check("post_rst_inReady", bus.inReady, 1);
    endtask

    task automatic run_load(input string tag, input logic [15:0] n, input logic [7:0] d[$],
                            input int unsigned max_gap, input bit exp_done, input bit exp_err,
                            input int unsigned exp_writes, input int tr_ovr);
        wr_t exp[$];
        bit ok, acc;
        int unsigned n_acc;
        int hdr_cyc;
        logic [7:0] x;
        wr_q.delete();
        done_cyc = -1;
        hold_cyc = -1;
        model(n, d, exp, ok);
        x = n[15:8] ^ n[7:0];
        send_byte(n[15:8], 0, 20, acc);
        check({tag, " hdr_hi_acc"}, acc, 1);
        send_byte(n[7:0], 0, 20, acc);
        check({tag, " hdr_lo_acc"}, acc, 1);
        hdr_cyc = cyc;
        n_acc = 0;
        foreach (d[i]) begin
            send_byte(d[i], (max_gap == 0) ? 0 : $urandom_range(max_gap, 0), ok ? 20 : 4, acc);
            if (acc) begin
                n_acc++;
                x ^= d[i];
            end
        end
        check({tag, " bytes_acc"}, n_acc, ok ? d.size() : 0);
`ifdef MIPS_PROG_LOADER_CHECKSUM_EN
        if (ok) begin
            send_byte((tr_ovr < 0) ? x : 8'(tr_ovr), 0, 20, acc);
            check({tag, " trailer_acc"}, acc, 1);
        end
`endif
        bus.inValid = 1'b0;
        for (int i = 0; i < 10 && !(done || error); i++) @(negedge clk);
        @(negedge clk);
        check({tag, " done"}, done, exp_done);
        check({tag, " error"}, error, exp_err);
        check({tag, " coreHold"}, coreHold, !exp_done);
        check({tag, " inReady_end"}, bus.inReady, 0);
        check({tag, " n_writes"}, wr_q.size(), exp_writes);
        check({tag, " n_writes_model"}, wr_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wr_q.size(); i++) begin
            check($sformatf("%s wr%0d_addr", tag, i), wr_q[i].addr, exp[i].addr);
            check($sformatf("%s wr%0d_data", tag, i), wr_q[i].data, exp[i].data);
        end
`ifndef MIPS_PROG_LOADER_CHECKSUM_EN
        if (exp_done && wr_q.size() > 0) begin
            check({tag, " done_after_last_wr"}, done_cyc - wr_q[wr_q.size()-1].cyc, 1);
            check({tag, " hold_after_last_wr"}, hold_cyc - wr_q[wr_q.size()-1].cyc, 1);
        end else if (exp_done) begin
            check({tag, " done_within_2"}, (done_cyc >= 0) && (done_cyc - hdr_cyc <= 2), 1);
        end
`endif
        if (tr_ovr == -2) $display("note: %s %0d", tag, hdr_cyc);
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL global_timeout: got still-running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        logic [7:0] d[$];
        logic [15:0] n;
        bit ok;
        int unsigned nd;

        vecs[0] = '{16'd2,      0, 1'b1, 1'b0, 2};
        vecs[1] = '{16'd0,      0, 1'b1, 1'b0, 0};
        vecs[2] = '{16'd65,     0, 1'b0, 1'b1, 0};
        vecs[3] = '{16'd64,     0, 1'b1, 1'b0, 64};
        vecs[4] = '{16'd3,      3, 1'b1, 1'b0, 3};
        vecs[5] = '{16'd1,      5, 1'b1, 1'b0, 1};
        vecs[6] = '{16'h0100,   0, 1'b0, 1'b1, 0};
        vecs[7] = '{16'hFFFF,   0, 1'b0, 1'b1, 0};

        bus.inValid = 1'b0;
        bus.inData  = '0;
        @(negedge clk);
        do_reset(1'b1);

        d = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load("two_words", 16'd2, d, 0, 1'b1, 1'b0, 2, -1);

        do_reset(1'b0);
        d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load("gapped", 16'd1, d, 5, 1'b1, 1'b0, 1, -1);

        for (int v = 0; v < 8; v++) begin
            do_reset(1'b0);
            d.delete();
            nd = vecs[v].exp_err ? 8 : 4 * int'(vecs[v].n);
            for (int unsigned i = 0; i < nd; i++) d.push_back(8'($urandom));
            run_load($sformatf("vec%0d", v), vecs[v].n, d, vecs[v].max_gap,
                     vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_writes, -1);
        end

        // Reset part-way through the second word, then a fresh load from address 0.
        do_reset(1'b0);
        wr_q.delete();
        begin
            bit acc;
            logic [7:0] mid[8];
            mid = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
            send_byte(8'h00, 0, 20, acc);
            send_byte(8'h02, 0, 20, acc);
            for (int i = 0; i < 6; i++) send_byte(mid[i], 0, 20, acc);
            check("mid wr_count", wr_q.size(), 1);
            if (wr_q.size() > 0) check("mid wr0_data", wr_q[0].data, 32'h11223344);
        end
        do_reset(1'b1);
        d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_load("after_reset", 16'd1, d, 0, 1'b1, 1'b0, 1, -1);

        for (int r = 0; r < 6; r++) begin
            do_reset(1'b0);
            n = ($urandom_range(4, 0) == 0) ? 16'($urandom_range(300, 65))
                                            : 16'($urandom_range(12, 0));
            ok = (int'(n) <= int'(ADDR_L));
            d.delete();
            nd = ok ? 4 * int'(n) : 8;
            for (int unsigned i = 0; i < nd; i++) d.push_back(8'($urandom));
            run_load($sformatf("rnd%0d", r), n, d, $urandom_range(3, 0), ok, !ok,
                     ok ? int'(n) : 0, -1);
        end

`ifdef MIPS_PROG_LOADER_CHECKSUM_EN
        do_reset(1'b0);
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load("csum_ok", 16'd1, d, 0, 1'b1, 1'b0, 1, 8'h05);
        do_reset(1'b0);
        run_load("csum_bad", 16'd1, d, 0, 1'b0, 1'b1, 1, 8'h06);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Boot-time writer for the core's instruction memory, the write side of the instruction-fetch read port.
- Accepts a byte stream (valid/ready), assembles big-endian 32-bit words and writes them to consecutive instruction-memory addresses from 0.
- Holds the core in reset until the image is complete, then releases it.
- Sits beside Mips_mips in the top-level, replacing the static MIF preload when a runtime-loaded program is needed.

Parameters:
- ADDR_L, 64, instruction-memory depth in words.
- ADDR_W, log2(ADDR_L), word-address width.
- CNT_W, 16, width of the word-count header field.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- inData  input  8  stream byte.
- inValid  input  1  inData valid.
- inReady  output  1  loader accepts a byte this cycle.
- memWrEn  output  1  instruction-memory write strobe, one cycle per word.
- memWrAddr  output  ADDR_W  word address.
- memWrData  output  32  word to write.
- coreHold  output  1  high = core held in reset.
- done  output  1  load completed successfully.
- error  output  1  load aborted.

Behaviour:
- Reset values:
  - State = HDR_HI.
  - inReady = 0 during reset, 1 from the first clock edge after reset deasserts.
  - memWrEn = 0, memWrAddr = 0, memWrData = 0.
  - coreHold = 1, done = 0, error = 0.
  - Byte counter = 0, word counter = 0.
- Handshake: a byte transfers on a rising edge with inValid & inReady. inReady = 1 only in states HDR_HI, HDR_LO, DATA (and CSUM if enabled). inData is ignored otherwise.
- Header: 2 bytes, big-endian word count N (CNT_W bits).
- State transitions:
  - HDR_HI → HDR_LO on accept; latch N[15:8].
  - HDR_LO on accept, latching N[7:0]:
    - N > ADDR_L → ERROR.
    - N == 0 → CSUM if LOADER_CHECKSUM_EN, else DONE.
    - Otherwise → DATA.
  - DATA: bytes accumulate MSB-first into a 32-bit shift register.
    - On the 4th byte accept, the next cycle presents memWrEn = 1, memWrAddr = word counter, memWrData = assembled word.
    - Word counter increments by 1.
    - inReady stays 1, so a new byte may be accepted in the write cycle with no bubble.
  - After the N-th word's 4th byte → CSUM if enabled, else DONE. The final memWrEn pulse occurs in the first DONE/CSUM cycle.
  - DONE: terminal. done = 1 and coreHold = 0, both registered, asserted the cycle after the final memWrEn. Further inputs are ignored.
  - ERROR: terminal. error = 1, coreHold stays 1, inReady = 0. Exit only via reset.
- Gaps: inValid low holds all state. Byte position and word count are preserved indefinitely.
- Wrap-around: the word counter never wraps. The N ≤ ADDR_L check guarantees the maximum address is ADDR_L-1.
- Reset mid-load: outputs return to reset values asynchronously. Memory contents already written are not cleared, and a subsequent load overwrites from address 0.
- memWrEn is never asserted outside a single cycle per completed word.

Optional Feature:
- Macro: MIPS_PROG_LOADER_CHECKSUM_EN.
- With the macro:
  - Running XOR of every accepted header and data byte.
  - CSUM state accepts one trailer byte.
  - Trailer equal to the running XOR → DONE; mismatch → ERROR.
  - coreHold is released only on match.
- Without the macro: no CSUM state, no trailer byte; DONE directly after the last word.

Decomposition:
- Shared package: state encoding constants (HDR_HI, HDR_LO, DATA, CSUM, DONE, ERROR), header width CNT_W, word width 32, and the log2 helper already shared.
- One sub-module, mips_prog_loader_packer:
  - Byte-to-word shift register with a 2-bit byte index.
  - Emits a one-cycle word-valid pulse with the assembled word.
- The top FSM owns the counters, header, checksum and outputs.

Test Plan:
- Header 00 02, bytes 12 34 56 78 9A BC DE F0, inValid continuous → writes (0, 0x12345678), (1, 0x9ABCDEF0). done = 1 and coreHold = 0 one cycle after the 2nd write.
- Header 00 00 → no memWrEn, done = 1 within 2 cycles of header completion (checksum disabled).
- Header 00 41 (65 > 64) → error = 1, inReady = 0, coreHold = 1; no writes for any later bytes.
- Header 00 01, data bytes separated by random 0–5 cycle inValid gaps → single write (0, 0xDEADBEEF), no spurious strobes.
- Reset pulsed low after 6 of 8 data bytes → all outputs at reset values immediately. A fresh 1-word load then writes address 0 correctly.
- With MIPS_PROG_LOADER_CHECKSUM_EN: header 00 01, data 01 02 03 04:
  - Trailer 0x05 (00^01^01^02^03^04) → done.
  - Trailer 0x06 → error, coreHold stays 1.
